// File: rtl/ahb_crypto_pkg.sv
// Shared types and constants for the AHB-Lite crypto slave and its decoder.
package ahb_crypto_pkg;

  localparam int unsigned MAX_CH = 4;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STALL,
    ST_ERR1,
    ST_ERR2
  } state_e;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_STATUS,
    OP_ENC,
    OP_DEC,
    OP_KEY,
    OP_IN,
    OP_OUT
  } op_e;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [7:0] OFF_STATUS   = 8'h00;
  localparam logic [7:0] OFF_ENC      = 8'h04;
  localparam logic [7:0] OFF_DEC      = 8'h08;
  localparam logic [7:0] OFF_KEY      = 8'h10;
  localparam logic [7:0] OFF_IN       = 8'h40;
  localparam logic [7:0] OFF_IN_LAST  = 8'h7C;
  localparam logic [7:0] OFF_OUT      = 8'h80;
  localparam logic [7:0] OFF_OUT_LAST = 8'hDC;

  localparam int unsigned STAT_KEY_DONE = 0;
  localparam int unsigned STAT_RCV_FULL = 1;
  localparam int unsigned STAT_TX_EMPTY = 2;
  localparam int unsigned STAT_BUSY     = 3;

  // Registered address-phase information carried into the data phase
  typedef struct packed {
    op_e        op;
    logic [1:0] ch;
    logic [2:0] key_idx;
  } dphase_t;

  function automatic logic [MAX_CH-1:0] ch_onehot(input logic [1:0] ch);
    return MAX_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/ahb_crypto_decode.sv
// Address-phase decode: classifies the access, extracts channel/key index
// and flags every illegal combination before the data phase starts.
module ahb_crypto_decode
  import ahb_crypto_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned KEY_WORDS = 4
) (
  input  logic [9:0]        haddr_i,
  input  logic              hwrite_i,
  input  logic [2:0]        hsize_i,
  input  logic [NUM_CH-1:0] key_done_i,
  input  logic [NUM_CH-1:0] busy_i,
  output op_e               op_o,
  output logic [1:0]        ch_o,
  output logic [2:0]        key_idx_o,
  output logic              err_o
);

  localparam logic [7:0] OFF_KEY_LAST = 8'(OFF_KEY + 4 * (KEY_WORDS - 1));
  localparam logic [2:0] NUM_CH_L     = 3'(NUM_CH);

  logic [7:0]        off;
  logic [MAX_CH-1:0] key_done_pad;
  logic [MAX_CH-1:0] busy_pad;
  logic              dir_ok;
  logic              win_access;
  logic              cmd_access;

  assign off          = haddr_i[7:0];
  assign ch_o         = haddr_i[9:8];
  assign key_done_pad = MAX_CH'(key_done_i);
  assign busy_pad     = MAX_CH'(busy_i);

  // Offset classification
  always_comb begin
    op_o      = OP_NONE;
    key_idx_o = '0;
    if (off == OFF_STATUS) begin
      op_o = OP_STATUS;
    end else if (off == OFF_ENC) begin
      op_o = OP_ENC;
    end else if (off == OFF_DEC) begin
      op_o = OP_DEC;
    end else if (off >= OFF_KEY && off <= OFF_KEY_LAST) begin
      op_o      = OP_KEY;
      key_idx_o = 3'((off - OFF_KEY) >> 2);
    end else if (off >= OFF_IN && off <= OFF_IN_LAST) begin
      op_o = OP_IN;
    end else if (off >= OFF_OUT && off <= OFF_OUT_LAST) begin
      op_o = OP_OUT;
    end
  end

  always_comb begin
    dir_ok = 1'b0;
    case (op_o)
      OP_STATUS, OP_OUT:             dir_ok = !hwrite_i;
      OP_ENC, OP_DEC, OP_KEY, OP_IN: dir_ok = hwrite_i;
      default:                       dir_ok = 1'b0;
    endcase
  end

  assign win_access = (op_o == OP_IN) || (op_o == OP_OUT);
  assign cmd_access = (op_o == OP_ENC) || (op_o == OP_DEC);

  // Unmapped offsets fall out through dir_ok, since OP_NONE has no legal direction
  assign err_o = (hsize_i != HSIZE_WORD)
              || (haddr_i[1:0] != 2'b00)
              || ({1'b0, ch_o} >= NUM_CH_L)
              || !dir_ok
              || (win_access && !key_done_pad[ch_o])
              || (cmd_access && busy_pad[ch_o]);

endmodule

// File: rtl/ahb_crypto_slave.sv
// AHB-Lite slave front end for a bank of cipher channels: FIFO windows,
// key loading, command strobes, wait-state timeout and two-cycle ERROR.
module ahb_crypto_slave
  import ahb_crypto_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned KEY_WORDS = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [31:0]          HWDATA,
  output logic [31:0]          HRDATA,
  output logic                 HREADY,
  output logic                 HRESP,
  input  logic [NUM_CH-1:0]    key_done,
  input  logic [NUM_CH-1:0]    rcv_full,
  input  logic [NUM_CH-1:0]    tx_empty,
  input  logic [NUM_CH-1:0]    busy,
  input  logic [NUM_CH*32-1:0] tx_rdata,
  output logic [NUM_CH-1:0]    rcv_enq,
  output logic [NUM_CH-1:0]    tx_deq,
  output logic [NUM_CH-1:0]    key_we,
  output logic [NUM_CH-1:0]    key_last,
  output logic [NUM_CH-1:0]    enc_pulse,
  output logic [NUM_CH-1:0]    dec_pulse,
  output logic [31:0]          wdata,
  output logic [2:0]           key_idx
);

  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]       KEY_IDX_LAST = 3'(KEY_WORDS - 1);

  state_e           state_q;
  logic             dp_valid_q;
  dphase_t          dp_q;
  logic [CNT_W-1:0] cnt_q;

  op_e        dec_op;
  logic [1:0] dec_ch;
  logic [2:0] dec_key_idx;
  logic       dec_err;

  logic [MAX_CH-1:0]    rcv_full_pad;
  logic [MAX_CH-1:0]    tx_empty_pad;
  logic [MAX_CH-1:0]    key_done_pad;
  logic [MAX_CH-1:0]    busy_pad;
  logic [MAX_CH*32-1:0] tx_rdata_pad;
  logic [NUM_CH-1:0]    ch_sel;
  logic [31:0]          status_c;
  logic                 accept_c;
  logic                 blocked_c;
  logic                 timeout_c;
  logic                 done_c;
  logic                 unused_c;

  ahb_crypto_decode #(
    .NUM_CH    (NUM_CH),
    .KEY_WORDS (KEY_WORDS)
  ) u_decode (
    .haddr_i    (HADDR[9:0]),
    .hwrite_i   (HWRITE),
    .hsize_i    (HSIZE),
    .key_done_i (key_done),
    .busy_i     (busy),
    .op_o       (dec_op),
    .ch_o       (dec_ch),
    .key_idx_o  (dec_key_idx),
    .err_o      (dec_err)
  );

  assign rcv_full_pad = MAX_CH'(rcv_full);
  assign tx_empty_pad = MAX_CH'(tx_empty);
  assign key_done_pad = MAX_CH'(key_done);
  assign busy_pad     = MAX_CH'(busy);
  assign tx_rdata_pad = (MAX_CH*32)'(tx_rdata);
  assign ch_sel       = NUM_CH'(ch_onehot(dp_q.ch));

  // Burst type and upper address bits carry no information for this slave
  assign unused_c = ^{HBURST, HADDR[31:10]};

  // A pending data phase waits while its FIFO cannot take or give a word
  assign blocked_c = dp_valid_q
                  && (((dp_q.op == OP_IN)  && rcv_full_pad[dp_q.ch])
                   || ((dp_q.op == OP_OUT) && tx_empty_pad[dp_q.ch]));
  assign timeout_c = blocked_c && (cnt_q >= CNT_LAST);
  assign done_c    = dp_valid_q && !blocked_c && !HRESET;
  assign accept_c  = HSEL && HREADY
                  && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    if (!HRESET) begin
      case (state_q)
        ST_ERR1: begin
          HREADY = 1'b0;
          HRESP  = 1'b1;
        end
        ST_ERR2: HRESP  = 1'b1;
        default: HREADY = !blocked_c;
      endcase
    end
  end

  always_comb begin
    status_c                = '0;
    status_c[STAT_KEY_DONE] = key_done_pad[dp_q.ch];
    status_c[STAT_RCV_FULL] = rcv_full_pad[dp_q.ch];
    status_c[STAT_TX_EMPTY] = tx_empty_pad[dp_q.ch];
    status_c[STAT_BUSY]     = busy_pad[dp_q.ch];
  end

  // Data-phase strobes and read data, live only in the completing cycle
  always_comb begin
    rcv_enq   = '0;
    tx_deq    = '0;
    key_we    = '0;
    key_last  = '0;
    enc_pulse = '0;
    dec_pulse = '0;
    wdata     = '0;
    key_idx   = '0;
    HRDATA    = '0;
    if (done_c) begin
      case (dp_q.op)
        OP_IN: begin
          rcv_enq = ch_sel;
          wdata   = HWDATA;
        end
        OP_OUT: begin
          tx_deq = ch_sel;
          HRDATA = tx_rdata_pad[{dp_q.ch, 5'b0} +: 32];
        end
        OP_KEY: begin
          key_we   = ch_sel;
          key_last = (dp_q.key_idx == KEY_IDX_LAST) ? ch_sel : '0;
          key_idx  = dp_q.key_idx;
          wdata    = HWDATA;
        end
        OP_ENC:    enc_pulse = ch_sel;
        OP_DEC:    dec_pulse = ch_sel;
        OP_STATUS: HRDATA    = status_c;
        default: ;
      endcase
    end
  end

  // Transfer FSM; ERR2 shares the idle path so a phase offered there is taken
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_q       <= '0;
    end else begin
      case (state_q)
        ST_ERR1: state_q <= ST_ERR2;
        default: begin
          if (blocked_c) begin
            if (timeout_c) begin
              state_q    <= ST_ERR1;
              dp_valid_q <= 1'b0;
              cnt_q      <= '0;
            end else begin
              state_q <= ST_STALL;
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end else begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dp_valid_q <= 1'b0;
            if (accept_c) begin
              if (dec_err) begin
                state_q <= ST_ERR1;
              end else begin
                dp_valid_q <= 1'b1;
                dp_q       <= '{op: dec_op, ch: dec_ch, key_idx: dec_key_idx};
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_crypto_slave.sv
// Directed bench for ahb_crypto_slave with two channels and four key words.
module tb_ahb_crypto_slave;
  import ahb_crypto_pkg::*;

  localparam int unsigned NUM_CH    = 2;
  localparam int unsigned KEY_WORDS = 4;
  localparam int unsigned TIMEOUT   = 16;

  logic                 HCLK;
  logic                 HRESET;
  logic                 HSEL;
  logic [31:0]          HADDR;
  logic [1:0]           HTRANS;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [2:0]           HBURST;
  logic [31:0]          HWDATA;
  logic [31:0]          HRDATA;
  logic                 HREADY;
  logic                 HRESP;
  logic [NUM_CH-1:0]    key_done;
  logic [NUM_CH-1:0]    rcv_full;
  logic [NUM_CH-1:0]    tx_empty;
  logic [NUM_CH-1:0]    busy;
  logic [NUM_CH*32-1:0] tx_rdata;
  logic [NUM_CH-1:0]    rcv_enq;
  logic [NUM_CH-1:0]    tx_deq;
  logic [NUM_CH-1:0]    key_we;
  logic [NUM_CH-1:0]    key_last;
  logic [NUM_CH-1:0]    enc_pulse;
  logic [NUM_CH-1:0]    dec_pulse;
  logic [31:0]          wdata;
  logic [2:0]           key_idx;

  int n_cmp;
  int n_bad;

  ahb_crypto_slave #(
    .NUM_CH    (NUM_CH),
    .KEY_WORDS (KEY_WORDS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .HRDATA    (HRDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .key_done  (key_done),
    .rcv_full  (rcv_full),
    .tx_empty  (tx_empty),
    .busy      (busy),
    .tx_rdata  (tx_rdata),
    .rcv_enq   (rcv_enq),
    .tx_deq    (tx_deq),
    .key_we    (key_we),
    .key_last  (key_last),
    .enc_pulse (enc_pulse),
    .dec_pulse (dec_pulse),
    .wdata     (wdata),
    .key_idx   (key_idx)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HADDR  = 32'h0;
    HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0;
    HSIZE  = HSIZE_WORD;
    HBURST = HBURST_SINGLE;
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                         input logic [1:0] tr);
    HSEL   = 1'b1;
    HADDR  = a;
    HWRITE = wr;
    HSIZE  = sz;
    HTRANS = tr;
    HBURST = HBURST_SINGLE;
  endtask

  function automatic logic [31:0] all_strobes();
    return 32'({rcv_enq, tx_deq, key_we, key_last, enc_pulse, dec_pulse});
  endfunction

  // Entered mid-ERR1, leaves mid-ERR2
  task automatic expect_error(input string tag);
    chk_eq({tag, "_e1_hready"}, 32'(HREADY), 32'd0);
    chk_eq({tag, "_e1_hresp"}, 32'(HRESP), 32'd1);
    chk_eq({tag, "_e1_strobes"}, all_strobes(), 32'd0);
    step();
    bus_idle();
    #3;
    chk_eq({tag, "_e2_hready"}, 32'(HREADY), 32'd1);
    chk_eq({tag, "_e2_hresp"}, 32'(HRESP), 32'd1);
    chk_eq({tag, "_e2_strobes"}, all_strobes(), 32'd0);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    HRESET   = 1'b1;
    HWDATA   = 32'h0;
    key_done = 2'b01;
    rcv_full = 2'b00;
    tx_empty = 2'b11;
    busy     = 2'b00;
    tx_rdata = {32'hCAFEF00D, 32'h12345678};
    bus_idle();
    repeat (3) @(posedge HCLK);
    #4;
    chk_eq("rst_hready", 32'(HREADY), 32'd1);
    chk_eq("rst_hresp", 32'(HRESP), 32'd0);
    chk_eq("rst_hrdata", HRDATA, 32'd0);
    chk_eq("rst_strobes", all_strobes(), 32'd0);
    chk_eq("rst_wdata", wdata, 32'd0);
    chk_eq("rst_key_idx", 32'(key_idx), 32'd0);
    step();
    HRESET = 1'b0;

    // Input window write on ch0 with a free FIFO
    step(); addr_ph(32'h040, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    step(); bus_idle(); HWDATA = 32'hDEADBEEF; #3;
    chk_eq("in_rcv_enq", 32'(rcv_enq), 32'h1);
    chk_eq("in_wdata", wdata, 32'hDEADBEEF);
    chk_eq("in_hready", 32'(HREADY), 32'd1);
    chk_eq("in_hresp", 32'(HRESP), 32'd0);
    chk_eq("in_hrdata", HRDATA, 32'd0);
    step(); #3;
    chk_eq("in_rcv_enq_once", 32'(rcv_enq), 32'h0);
    chk_eq("in_wdata_clr", wdata, 32'd0);

    // Input window on ch1 without a key is refused
    step(); addr_ph(32'h140, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    step(); bus_idle(); HWDATA = 32'h11111111; #3;
    expect_error("nokey");
    step(); #3;
    chk_eq("nokey_after_hresp", 32'(HRESP), 32'd0);

    // Output read stalled by an empty tx FIFO for five cycles
    step(); addr_ph(32'h080, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    for (int i = 0; i < 5; i++) begin
      step(); bus_idle(); #3;
      chk_eq($sformatf("rd_stall%0d_hready", i), 32'(HREADY), 32'd0);
      chk_eq($sformatf("rd_stall%0d_deq", i), 32'(tx_deq), 32'd0);
      chk_eq($sformatf("rd_stall%0d_hrdata", i), HRDATA, 32'd0);
    end
    step(); tx_empty = 2'b10; #3;
    chk_eq("rd_hready", 32'(HREADY), 32'd1);
    chk_eq("rd_hrdata", HRDATA, 32'h12345678);
    chk_eq("rd_tx_deq", 32'(tx_deq), 32'h1);
    chk_eq("rd_hresp", 32'(HRESP), 32'd0);
    step(); #3;
    chk_eq("rd_tx_deq_once", 32'(tx_deq), 32'h0);
    chk_eq("rd_hrdata_clr", HRDATA, 32'd0);

    // Input write held by a full FIFO until the stall limit
    rcv_full = 2'b01;
    step(); addr_ph(32'h044, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    for (int i = 0; i < 16; i++) begin
      step(); bus_idle(); HWDATA = 32'hBAD0BAD0; #3;
      chk_eq($sformatf("to_stall%0d_hready", i), 32'(HREADY), 32'd0);
      chk_eq($sformatf("to_stall%0d_hresp", i), 32'(HRESP), 32'd0);
      chk_eq($sformatf("to_stall%0d_enq", i), 32'(rcv_enq), 32'd0);
    end
    step(); #3;
    expect_error("timeout");
    step(); rcv_full = 2'b00; #3;
    chk_eq("timeout_no_late_enq", 32'(rcv_enq), 32'd0);
    chk_eq("timeout_hready", 32'(HREADY), 32'd1);

    // Four-beat key burst on ch0
    for (int b = 0; b <= 4; b++) begin
      step();
      if (b < 4) begin
        addr_ph(32'(32'h10 + 4 * b), 1'b1, HSIZE_WORD,
                (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
        HBURST = HBURST_INCR4;
      end else begin
        bus_idle();
      end
      HWDATA = 32'(32'hA5A50000 + b);
      #3;
      if (b > 0) begin
        chk_eq($sformatf("key%0d_we", b - 1), 32'(key_we), 32'h1);
        chk_eq($sformatf("key%0d_idx", b - 1), 32'(key_idx), 32'(b - 1));
        chk_eq($sformatf("key%0d_last", b - 1), 32'(key_last), (b == 4) ? 32'h1 : 32'h0);
        chk_eq($sformatf("key%0d_wdata", b - 1), wdata, 32'(32'hA5A50000 + b));
        chk_eq($sformatf("key%0d_hready", b - 1), 32'(HREADY), 32'd1);
      end
    end
    step(); #3;
    chk_eq("key_we_clr", 32'(key_we), 32'h0);

    // Halfword encrypt is refused; a legal one offered during ERR2 follows
    step(); addr_ph(32'h004, 1'b1, 3'b001, HTRANS_NONSEQ);
    step(); bus_idle(); #3;
    expect_error("hsize");
    addr_ph(32'h004, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    step(); bus_idle(); #3;
    chk_eq("enc_pulse", 32'(enc_pulse), 32'h1);
    chk_eq("enc_hresp", 32'(HRESP), 32'd0);
    chk_eq("enc_hready", 32'(HREADY), 32'd1);
    step(); #3;
    chk_eq("enc_pulse_once", 32'(enc_pulse), 32'h0);

    // Encrypt on a busy channel is refused, decrypt on the idle one proceeds
    busy = 2'b01;
    step(); addr_ph(32'h004, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    step(); bus_idle(); #3;
    expect_error("busy");
    step(); addr_ph(32'h108, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    step(); bus_idle(); #3;
    chk_eq("dec_ch1", 32'(dec_pulse), 32'h2);
    chk_eq("dec_no_enc", 32'(enc_pulse), 32'h0);

    // Back-to-back status reads on both channels
    rcv_full = 2'b10;
    tx_empty = 2'b01;
    step(); addr_ph(32'h000, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
    step(); addr_ph(32'h100, 1'b0, HSIZE_WORD, HTRANS_NONSEQ); #3;
    chk_eq("status_ch0", HRDATA, 32'hD);
    step(); bus_idle(); #3;
    chk_eq("status_ch1", HRDATA, 32'h2);
    busy     = 2'b00;
    rcv_full = 2'b00;

    // IDLE transfer type is a zero-wait no-op
    step(); addr_ph(32'h004, 1'b1, HSIZE_WORD, HTRANS_IDLE);
    step(); bus_idle(); #3;
    chk_eq("idle_hready", 32'(HREADY), 32'd1);
    chk_eq("idle_hresp", 32'(HRESP), 32'd0);
    chk_eq("idle_strobes", all_strobes(), 32'd0);

    // Misaligned address
    step(); addr_ph(32'h042, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    step(); bus_idle(); #3;
    expect_error("unaligned");

    // Reset during the third stall cycle drops the pending write
    rcv_full = 2'b01;
    step(); addr_ph(32'h048, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
    step(); bus_idle(); HWDATA = 32'h0BADF00D; #3;
    chk_eq("rst_stall1_hready", 32'(HREADY), 32'd0);
    step(); #3;
    chk_eq("rst_stall2_hready", 32'(HREADY), 32'd0);
    step(); HRESET = 1'b1; #3;
    chk_eq("rst_stall3_enq", 32'(rcv_enq), 32'd0);
    step(); HRESET = 1'b0; rcv_full = 2'b00; #3;
    chk_eq("rst_after_hready", 32'(HREADY), 32'd1);
    chk_eq("rst_after_hresp", 32'(HRESP), 32'd0);
    chk_eq("rst_after_enq", 32'(rcv_enq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_crypto_slave.md
AHB_CRYPTO_SLAVE -- requirements
Module: ahb_crypto_slave

Interface
- REQ-001 SHALL have parameter NUM_CH, default 2: number of independent cipher channels (1..4).
- REQ-002 SHALL have parameter KEY_WORDS, default 4: 32-bit key words per channel (4 or 8).
- REQ-003 SHALL have parameter TIMEOUT, default 16: maximum wait-state cycles before a stalled transfer errors (1..255).
- REQ-004 SHALL have HCLK, input, 1: the only clock. HRESET, input, 1: reset, synchronous and active-high.
- REQ-005 SHALL have AHB-Lite slave inputs: HSEL (1), HADDR (32), HTRANS (2), HWRITE (1), HSIZE (3), HBURST (3), HWDATA (32).
- REQ-006 SHALL have AHB-Lite slave outputs: HRDATA (32), HREADY (1), HRESP (1; 0=OKAY, 1=ERROR).
- REQ-007 SHALL have per-channel inputs, each NUM_CH wide: key_done, rcv_full, tx_empty, busy. It SHALL also have tx_rdata, input, NUM_CH*32: head word of each tx FIFO.
- REQ-008 SHALL have per-channel strobe outputs, each NUM_CH wide: rcv_enq, tx_deq, key_we, key_last, enc_pulse, dec_pulse.
- REQ-009 SHALL have wdata (32) and key_idx (3) outputs.

Function
- REQ-010 Address map: ch = HADDR[9:8]; off = HADDR[7:0]. Offsets:
  - 0x00 status (read)
  - 0x04 encrypt (write)
  - 0x08 decrypt (write)
  - 0x10..0x10+4*(KEY_WORDS-1) key (write)
  - 0x40..0x7C input window (write)
  - 0x80..0xDC output window (read)
- REQ-011 An address phase SHALL be accepted only when HSEL=1, HTRANS is NONSEQ or SEQ, and HREADY=1. Addr/ctrl are registered; all actions occur in the following data phase.
- REQ-012 IDLE and BUSY HTRANS SHALL get a zero-wait OKAY response with no strobes.
- REQ-013 An accepted transfer SHALL be an error if any of the following holds:
  - HSIZE!=3'b010
  - HADDR[1:0]!=0
  - ch>=NUM_CH
  - unmapped offset
  - wrong direction for the offset
  - input or output window access while key_done[ch]=0
  - encrypt or decrypt write while busy[ch]=1
- REQ-014 Error response SHALL be two cycles: (HREADY=0, HRESP=1) then (HREADY=1, HRESP=1). No strobe SHALL fire.
- REQ-015 Input write: if rcv_full[ch]=0, rcv_enq[ch] SHALL pulse for one cycle with wdata=HWDATA and HREADY=1. Otherwise the block SHALL hold HREADY=0 and enqueue in the first cycle rcv_full drops.
- REQ-016 Output read: if tx_empty[ch]=0, HRDATA SHALL equal tx_rdata[ch] and tx_deq[ch] SHALL pulse in the same cycle with HREADY=1. Otherwise the block SHALL stall until tx_empty drops.
- REQ-017 A stall counter SHALL count stall cycles. On reaching TIMEOUT the transfer SHALL convert to the REQ-014 error with no strobe.
- REQ-018 Key write SHALL pulse key_we[ch] with key_idx=(off-0x10)>>2 and wdata=HWDATA. The write to index KEY_WORDS-1 SHALL also pulse key_last[ch].
- REQ-019 Encrypt or decrypt write SHALL pulse enc_pulse[ch] or dec_pulse[ch] for exactly one cycle.
- REQ-020 Status read SHALL return HRDATA={28'b0, busy[ch], tx_empty[ch], rcv_full[ch], key_done[ch]}.
- REQ-021 HRDATA SHALL be 0 in every cycle that is not a valid read data phase.
- REQ-022 State machine SHALL have states IDLE, STALL, ERR1, ERR2:
  - IDLE->STALL on a FIFO-blocked transfer.
  - STALL->IDLE when the condition clears.
  - STALL->ERR1 at timeout.
  - IDLE->ERR1 on an illegal transfer.
  - ERR1->ERR2 unconditionally; ERR2->IDLE unconditionally.
- REQ-023 No new address phase SHALL be accepted in STALL or ERR1. A phase presented during ERR2 (HREADY=1) SHALL be accepted.
- REQ-024 Back-to-back SEQ beats SHALL complete one per cycle when unblocked. Different channels SHALL be independent.

Reset
- REQ-025 While HRESET=1 at a rising HCLK edge:
  - state=IDLE, stall counter=0
  - HREADY=1, HRESP=0, HRDATA=0
  - all strobes 0, wdata=0, key_idx=0
  - any pending data phase discarded
- REQ-026 Reset asserted during STALL or ERR1/ERR2 SHALL abort the transfer with no strobe on the following cycle.

Structure
- REQ-027 A shared package ahb_crypto_pkg SHALL hold:
  - the state enum
  - HTRANS and HBURST codes
  - offset constants (OFF_STATUS, OFF_ENC, OFF_DEC, OFF_KEY, OFF_IN, OFF_OUT)
  - the status bit positions
- REQ-028 The decode and legality check SHALL be a sub-module ahb_crypto_decode (combinational; outputs op class, ch, error flag). The FSM, registers and counter SHALL live in ahb_crypto_slave.

Verification
- REQ-029 NUM_CH=2, key_done=2'b01: write 0x040 (ch0 input) with HWDATA=0xDEADBEEF -> rcv_enq=2'b01 for one cycle, wdata=0xDEADBEEF, HREADY=1. Write 0x140 -> two-cycle ERROR, no strobe.
- REQ-030 Output read 0x080 with tx_empty[0]=1 for 5 cycles, tx_rdata=0x12345678 -> HREADY=0 for 5 cycles, then HRDATA=0x12345678 and tx_deq[0] pulse.
- REQ-031 TIMEOUT=16, rcv_full[0] held 1 -> HREADY=0 for 16 cycles, then ERR1/ERR2, no rcv_enq.
- REQ-032 KEY_WORDS=4, 4-beat INCR write to 0x010..0x01C -> key_we 4 pulses, key_idx 0,1,2,3, key_last only on beat 4.
- REQ-033 HSIZE=3'b001 write to 0x004 -> error. Subsequent legal write to 0x004 -> single enc_pulse[0].
- REQ-034 HRESET=1 asserted on cycle 3 of a stall -> next cycle HREADY=1, state IDLE, no strobe.
